mem_arbiter: RTL and testbench

//  Shares the single byte-wide synchronous RAM port between the instruction-fetch stage (IF) and the

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide RAM arbiter: FSM states and memory access lengths.
// The LEN_* values are also used by the pipeline stages that issue MEM requests.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        MM_RD = 2'd2,
        MM_WR = 2'd3
    } arb_state_t;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    // Index of the last byte of an access; the reserved length 11 behaves as a word.
    function automatic logic [2:0] len_last(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd0;
            LEN_H:   return 3'd1;
            default: return 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide synchronous RAM port between instruction fetch and the
// memory stage, splitting 1/2/4-byte accesses into little-endian byte cycles.
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mm_req,
    input  logic              mm_we,
    input  logic [1:0]        mm_len,
    input  logic [31:0]       mm_addr,
    input  logic [31:0]       mm_wdata,
    output logic [31:0]       mm_rdata,
    output logic              mm_done,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              stl_req
);
    import mem_arbiter_pkg::*;

    arb_state_t        state, state_d;
    logic [2:0]        cnt, cnt_d;
    logic [2:0]        last;
    logic [ADDR_W-1:0] base, base_d, ram_a_d;
    logic [1:0]        len, len_d;
    logic [31:0]       wdata, wdata_d;
    logic [31:0]       rbuf, asm_w, rd_word;
    logic [31:0]       if_data_d, mm_rdata_d;
    logic [7:0]        dout_d;
    logic              wr_q, wr_d;
    logic              if_done_d, mm_done_d;
    logic              grant;
    logic              cap_en;
    logic              skip_p1;
    logic [1:0]        rd_idx;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^{if_addr[31:ADDR_W], mm_addr[31:ADDR_W]};

    assign last    = len_last(len);
    assign ram_wr  = wr_q & rdy;
    assign stl_req = (mm_req & ~mm_done) | (if_req & ~if_done & ~if_flush);

    // While reading, ram_a holds byte cnt and ram_din carries byte cnt-1. After a rdy stall
    // ram_din reflects the held address instead, so capture is skipped for that one edge;
    // the byte in flight was already taken on the first stalled edge.
    assign rd_idx  = cnt[1:0] - 2'd1;
    assign cap_en  = ((state == IF_RD) || (state == MM_RD)) && (cnt != 3'd0) && !skip_p1;

    always_comb begin
        asm_w = rbuf;
        asm_w[{rd_idx, 3'b000} +: 8] = ram_din;
    end

    assign rd_word = cap_en ? asm_w : rbuf;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        base_d     = base;
        len_d      = len;
        wdata_d    = wdata;
        ram_a_d    = ram_a;
        dout_d     = ram_dout;
        wr_d       = 1'b0;
        if_done_d  = 1'b0;
        mm_done_d  = 1'b0;
        if_data_d  = if_data;
        mm_rdata_d = mm_rdata;
        grant      = 1'b0;

        unique case (state)
            IDLE: begin
                // mm_done/if_done still high means that request is being retired this cycle.
                if (mm_req && !mm_done) begin
                    grant   = 1'b1;
                    base_d  = mm_addr[ADDR_W-1:0];
                    ram_a_d = mm_addr[ADDR_W-1:0];
                    len_d   = mm_len;
                    wdata_d = mm_wdata;
                    cnt_d   = 3'd0;
                    if (mm_we) begin
                        dout_d = mm_wdata[7:0];
                        wr_d   = 1'b1;
                        if (len_last(mm_len) == 3'd0) begin
                            mm_done_d = 1'b1;
                        end else begin
                            state_d = MM_WR;
                            cnt_d   = 3'd1;
                        end
                    end else begin
                        state_d = MM_RD;
                    end
                end else if (if_req && !if_done && !if_flush) begin
                    grant   = 1'b1;
                    base_d  = if_addr[ADDR_W-1:0];
                    ram_a_d = if_addr[ADDR_W-1:0];
                    len_d   = LEN_W;
                    cnt_d   = 3'd0;
                    state_d = IF_RD;
                end
            end

            IF_RD, MM_RD: begin
                if ((state == IF_RD) && if_flush) begin
                    state_d = IDLE;
                end else if (cnt == last + 3'd1) begin
                    state_d = IDLE;
                    if (state == IF_RD) begin
                        if_done_d = 1'b1;
                        if_data_d = rd_word;
                    end else begin
                        mm_done_d  = 1'b1;
                        mm_rdata_d = rd_word;
                    end
                end else begin
                    cnt_d = cnt + 3'd1;
                    if (cnt != last) begin
                        ram_a_d = base + {{(ADDR_W-3){1'b0}}, cnt + 3'd1};
                    end
                end
            end

            MM_WR: begin
                ram_a_d = base + {{(ADDR_W-3){1'b0}}, cnt};
                dout_d  = wdata[{cnt[1:0], 3'b000} +: 8];
                wr_d    = 1'b1;
                if (cnt == last) begin
                    mm_done_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt + 3'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            ram_a    <= '0;
            ram_dout <= 8'h00;
            wr_q     <= 1'b0;
            if_done  <= 1'b0;
            mm_done  <= 1'b0;
            if_data  <= 32'h0;
            mm_rdata <= 32'h0;
            skip_p1  <= 1'b0;
        end else begin
            skip_p1 <= ~rdy;
            if (rdy) begin
                state    <= state_d;
                cnt      <= cnt_d;
                ram_a    <= ram_a_d;
                ram_dout <= dout_d;
                wr_q     <= wr_d;
                if_done  <= if_done_d;
                mm_done  <= mm_done_d;
                if_data  <= if_data_d;
                mm_rdata <= mm_rdata_d;
            end
        end
    end

    // Request context and the assembly buffer carry no reset; they are rewritten on each grant.
    always_ff @(posedge clk) begin
        if (rdy) begin
            base  <= base_d;
            len   <= len_d;
            wdata <= wdata_d;
        end
        if (cap_en) begin
            rbuf <= asm_w;
        end else if (rdy && grant) begin
            rbuf <= 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-wide RAM model plus cycle-exact scenario tasks.
module tb_mem_arbiter;
    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rdy = 1'b1;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'h0;
    logic              if_flush = 1'b0;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mm_req = 1'b0;
    logic              mm_we = 1'b0;
    logic [1:0]        mm_len = 2'b00;
    logic [31:0]       mm_addr = 32'h0;
    logic [31:0]       mm_wdata = 32'h0;
    logic [31:0]       mm_rdata;
    logic              mm_done;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic              stl_req;

    logic [7:0] ram_mem [0:(1<<ADDR_W)-1];
    int pass_cnt = 0;
    int total_cnt = 0;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_data(if_data), .if_done(if_done),
        .mm_req(mm_req), .mm_we(mm_we), .mm_len(mm_len), .mm_addr(mm_addr),
        .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mm_done(mm_done),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .stl_req(stl_req)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: data appears the cycle after the address.
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_a] <= ram_dout;
        ram_din <= ram_mem[ram_a];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total_cnt++; if (if_done !== 1'b0) $display("FAIL reset_if_done: got %b expected 0", if_done); else pass_cnt++;
        total_cnt++; if (mm_done !== 1'b0) $display("FAIL reset_mm_done: got %b expected 0", mm_done); else pass_cnt++;
        total_cnt++; if (ram_wr !== 1'b0) $display("FAIL reset_ram_wr: got %b expected 0", ram_wr); else pass_cnt++;
        total_cnt++; if (ram_a !== 17'h0) $display("FAIL reset_ram_a: got %h expected 0", ram_a); else pass_cnt++;
        total_cnt++; if (ram_dout !== 8'h0) $display("FAIL reset_ram_dout: got %h expected 0", ram_dout); else pass_cnt++;
        total_cnt++; if (if_data !== 32'h0) $display("FAIL reset_if_data: got %h expected 0", if_data); else pass_cnt++;
        total_cnt++; if (mm_rdata !== 32'h0) $display("FAIL reset_mm_rdata: got %h expected 0", mm_rdata); else pass_cnt++;
        total_cnt++; if (stl_req !== 1'b0) $display("FAIL reset_stl_req: got %b expected 0", stl_req); else pass_cnt++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_if_read();
        ram_mem[17'h100] = 8'h13; ram_mem[17'h101] = 8'h00;
        ram_mem[17'h102] = 8'h00; ram_mem[17'h103] = 8'h00;
        if_addr = 32'h100;
        if_req  = 1'b1;
        tick();
        total_cnt++; if (ram_a !== 17'h100) $display("FAIL ifrd_addr0: got %h expected 100", ram_a); else pass_cnt++;
        total_cnt++; if (stl_req !== 1'b1) $display("FAIL ifrd_stall0: got %b expected 1", stl_req); else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total_cnt++; if (if_done !== 1'b0) $display("FAIL ifrd_done_early k=%0d: got %b expected 0", k, if_done); else pass_cnt++;
            total_cnt++; if (stl_req !== 1'b1) $display("FAIL ifrd_stall k=%0d: got %b expected 1", k, stl_req); else pass_cnt++;
            if (k == 1) begin
                total_cnt++; if (ram_a !== 17'h101) $display("FAIL ifrd_addr1: got %h expected 101", ram_a); else pass_cnt++;
            end
        end
        tick();
        total_cnt++; if (if_done !== 1'b1) $display("FAIL ifrd_done: got %b expected 1", if_done); else pass_cnt++;
        total_cnt++; if (if_data !== 32'h00000013) $display("FAIL ifrd_data: got %h expected 00000013", if_data); else pass_cnt++;
        total_cnt++; if (stl_req !== 1'b0) $display("FAIL ifrd_stall_end: got %b expected 0", stl_req); else pass_cnt++;
        if_req = 1'b0;
        tick();
        total_cnt++; if (if_done !== 1'b0) $display("FAIL ifrd_pulse: got %b expected 0", if_done); else pass_cnt++;
        total_cnt++; if (if_data !== 32'h00000013) $display("FAIL ifrd_hold: got %h expected 00000013", if_data); else pass_cnt++;
    endtask

    task automatic test_mm_priority();
        logic [7:0] exp_b [4];
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ram_mem[17'h300] = 8'h78; ram_mem[17'h301] = 8'h56;
        ram_mem[17'h302] = 8'h34; ram_mem[17'h303] = 8'h12;
        mm_we = 1'b1; mm_len = 2'b10; mm_addr = 32'h200; mm_wdata = 32'hDEADBEEF; mm_req = 1'b1;
        if_addr = 32'h300; if_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total_cnt++; if (ram_wr !== 1'b1) $display("FAIL wr_en k=%0d: got %b expected 1", k, ram_wr); else pass_cnt++;
            total_cnt++; if (ram_a !== 17'(32'h200 + k)) $display("FAIL wr_addr k=%0d: got %h expected %h", k, ram_a, 17'(32'h200 + k)); else pass_cnt++;
            total_cnt++; if (ram_dout !== exp_b[k]) $display("FAIL wr_byte k=%0d: got %h expected %h", k, ram_dout, exp_b[k]); else pass_cnt++;
            total_cnt++; if (mm_done !== (k == 3)) $display("FAIL wr_done k=%0d: got %b expected %b", k, mm_done, (k == 3)); else pass_cnt++;
        end
        mm_req = 1'b0;
        tick();
        total_cnt++; if (ram_a !== 17'h300) $display("FAIL prio_if_grant: got %h expected 300", ram_a); else pass_cnt++;
        total_cnt++; if (ram_wr !== 1'b0) $display("FAIL prio_wr_off: got %b expected 0", ram_wr); else pass_cnt++;
        total_cnt++; if (mm_done !== 1'b0) $display("FAIL prio_mm_pulse: got %b expected 0", mm_done); else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total_cnt++; if (if_done !== 1'b0) $display("FAIL prio_if_early k=%0d: got %b expected 0", k, if_done); else pass_cnt++;
        end
        tick();
        total_cnt++; if (if_done !== 1'b1) $display("FAIL prio_if_done: got %b expected 1", if_done); else pass_cnt++;
        total_cnt++; if (if_data !== 32'h12345678) $display("FAIL prio_if_data: got %h expected 12345678", if_data); else pass_cnt++;
        if_req = 1'b0;
        total_cnt++;
        if ({ram_mem[17'h203], ram_mem[17'h202], ram_mem[17'h201], ram_mem[17'h200]} !== 32'hDEADBEEF)
            $display("FAIL wr_ram: got %h expected deadbeef",
                     {ram_mem[17'h203], ram_mem[17'h202], ram_mem[17'h201], ram_mem[17'h200]});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_wrap();
        ram_mem[17'h1FFFF] = 8'hA5;
        ram_mem[17'h00000] = 8'h3C;
        mm_we = 1'b0; mm_len = 2'b01; mm_addr = 32'h0001FFFF; mm_req = 1'b1;
        tick();
        total_cnt++; if (ram_a !== 17'h1FFFF) $display("FAIL wrap_addr0: got %h expected 1ffff", ram_a); else pass_cnt++;
        tick();
        total_cnt++; if (ram_a !== 17'h00000) $display("FAIL wrap_addr1: got %h expected 00000", ram_a); else pass_cnt++;
        total_cnt++; if (mm_done !== 1'b0) $display("FAIL wrap_early: got %b expected 0", mm_done); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (mm_done !== 1'b1) $display("FAIL wrap_done: got %b expected 1", mm_done); else pass_cnt++;
        total_cnt++; if (mm_rdata !== 32'h00003CA5) $display("FAIL wrap_data: got %h expected 00003ca5", mm_rdata); else pass_cnt++;
        mm_req = 1'b0;
        tick();
        mm_len = 2'b00; mm_addr = 32'h200; mm_req = 1'b1;
        tick();
        tick();
        tick();
        total_cnt++; if (mm_done !== 1'b1) $display("FAIL lb_done: got %b expected 1", mm_done); else pass_cnt++;
        total_cnt++; if (mm_rdata !== 32'h000000EF) $display("FAIL lb_zext: got %h expected 000000ef", mm_rdata); else pass_cnt++;
        mm_req = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        ram_mem[17'h40] = 8'h11; ram_mem[17'h41] = 8'h22;
        ram_mem[17'h42] = 8'h33; ram_mem[17'h43] = 8'h44;
        if_addr = 32'h500; if_req = 1'b1;
        tick();
        tick();
        if_flush = 1'b1;
        tick();
        total_cnt++; if (if_done !== 1'b0) $display("FAIL flush_no_done: got %b expected 0", if_done); else pass_cnt++;
        total_cnt++; if (stl_req !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stl_req); else pass_cnt++;
        if_flush = 1'b0; if_addr = 32'h40;
        tick();
        total_cnt++; if (ram_a !== 17'h40) $display("FAIL flush_regrant: got %h expected 40", ram_a); else pass_cnt++;
        total_cnt++; if (if_data !== 32'h12345678) $display("FAIL flush_data_kept: got %h expected 12345678", if_data); else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total_cnt++; if (if_done !== 1'b0) $display("FAIL flush_early k=%0d: got %b expected 0", k, if_done); else pass_cnt++;
        end
        tick();
        total_cnt++; if (if_done !== 1'b1) $display("FAIL flush_new_done: got %b expected 1", if_done); else pass_cnt++;
        total_cnt++; if (if_data !== 32'h44332211) $display("FAIL flush_new_data: got %h expected 44332211", if_data); else pass_cnt++;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_rdy_stall();
        ram_mem[17'h600] = 8'h11; ram_mem[17'h601] = 8'hEE;
        ram_mem[17'h602] = 8'hFF; ram_mem[17'h603] = 8'hC0;
        mm_we = 1'b0; mm_len = 2'b10; mm_addr = 32'h600; mm_req = 1'b1;
        tick();
        tick();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++; if (ram_wr !== 1'b0) $display("FAIL stall_wr k=%0d: got %b expected 0", k, ram_wr); else pass_cnt++;
            total_cnt++; if (ram_a !== 17'h601) $display("FAIL stall_addr k=%0d: got %h expected 601", k, ram_a); else pass_cnt++;
            total_cnt++; if (mm_done !== 1'b0) $display("FAIL stall_done k=%0d: got %b expected 0", k, mm_done); else pass_cnt++;
        end
        rdy = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            tick();
            total_cnt++; if (mm_done !== 1'b0) $display("FAIL stall_early k=%0d: got %b expected 0", k, mm_done); else pass_cnt++;
        end
        tick();
        total_cnt++; if (mm_done !== 1'b1) $display("FAIL stall_done_late: got %b expected 1", mm_done); else pass_cnt++;
        total_cnt++; if (mm_rdata !== 32'hC0FFEE11) $display("FAIL stall_data: got %h expected c0ffee11", mm_rdata); else pass_cnt++;
        mm_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        for (int i = 0; i < 4; i++) ram_mem[17'h700 + i] = 8'h55;
        mm_we = 1'b1; mm_len = 2'b10; mm_addr = 32'h700; mm_wdata = 32'h44332211; mm_req = 1'b1;
        tick();
        rst = 1'b0; mm_req = 1'b0;
        tick();
        total_cnt++; if (ram_wr !== 1'b0) $display("FAIL rstwr_wr: got %b expected 0", ram_wr); else pass_cnt++;
        total_cnt++; if (ram_a !== 17'h0) $display("FAIL rstwr_addr: got %h expected 0", ram_a); else pass_cnt++;
        total_cnt++; if (ram_dout !== 8'h0) $display("FAIL rstwr_dout: got %h expected 0", ram_dout); else pass_cnt++;
        total_cnt++; if (mm_done !== 1'b0) $display("FAIL rstwr_done: got %b expected 0", mm_done); else pass_cnt++;
        total_cnt++; if (if_data !== 32'h0) $display("FAIL rstwr_if_data: got %h expected 0", if_data); else pass_cnt++;
        total_cnt++; if (mm_rdata !== 32'h0) $display("FAIL rstwr_mm_rdata: got %h expected 0", mm_rdata); else pass_cnt++;
        rst = 1'b1;
        tick();
        tick();
        total_cnt++; if (mm_done !== 1'b0) $display("FAIL rstwr_late_done: got %b expected 0", mm_done); else pass_cnt++;
        total_cnt++; if (ram_mem[17'h700] !== 8'h11) $display("FAIL rstwr_byte0: got %h expected 11", ram_mem[17'h700]); else pass_cnt++;
        total_cnt++; if (ram_mem[17'h701] !== 8'h55) $display("FAIL rstwr_byte1: got %h expected 55", ram_mem[17'h701]); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = 8'h00;
        test_reset();
        test_if_read();
        test_mm_priority();
        test_wrap();
        test_flush();
        test_rdy_stall();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
